// File: rtl/nreg_arb_pkg.sv
// rtl/nreg_arb_pkg.sv - shared types and defaults for the NReg write arbiter
package nreg_arb_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ARB    = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Walk from pointer upward, wrapping at N; first hit wins.
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(pointer) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/nreg_arbiter.sv
// rtl/nreg_arbiter.sv - round-robin write arbiter with bounded lock in front of NReg
module nreg_arbiter
  import nreg_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_REQ-1:0]               io_req,
  input  logic [N_REQ-1:0]               io_lock,
  input  logic [N_REQ*WIDTH-1:0]         io_data,
  output logic [N_REQ-1:0]               io_gnt,
  output logic [WIDTH-1:0]               io_D,
  input  logic [WIDTH-1:0]               io_Q,
  output logic [WIDTH-1:0]               io_rd_data,
  output logic [owner_w(N_REQ)-1:0]      io_owner,
  output logic                           io_locked,
  output logic                           io_preempt
);

  localparam int OW = owner_w(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t      state, state_n;
  logic [OW-1:0]   pointer, pointer_n;
  logic [OW-1:0]   owner, owner_n;
  logic [HW-1:0]   hold_cnt, hold_n;

  logic [N_REQ-1:0] pick_gnt;
  logic [OW-1:0]    pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] owner_oh;
  logic             others_wait;

  rr_pick #(
    .N  (N_REQ),
    .IW (OW)
  ) u_pick (
    .req     (io_req),
    .pointer (pointer),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign owner_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
  assign others_wait = |(io_req & ~owner_oh);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      pointer  <= '0;
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      pointer  <= pointer_n;
      owner    <= owner_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n    = state;
    pointer_n  = pointer;
    owner_n    = owner;
    hold_n     = hold_cnt;
    io_gnt     = '0;
    io_D       = io_Q;
    io_preempt = 1'b0;
    case (state)
      ST_INIT: begin
        // Clear the register once; NReg has no reset of its own.
        io_D    = '0;
        state_n = ST_ARB;
      end
      ST_ARB: begin
        if (pick_any) begin
          io_gnt    = pick_gnt;
          io_D      = io_data[int'(pick_idx)*WIDTH +: WIDTH];
          pointer_n = next_ptr(pick_idx);
          if (io_lock[pick_idx]) begin
            state_n = ST_LOCKED;
            owner_n = pick_idx;
            hold_n  = HW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (hold_cnt == HW'(MAX_HOLD) && others_wait) begin
          // Force release: the waiting requester gets the next ARB cycle.
          io_preempt = 1'b1;
          pointer_n  = next_ptr(owner);
          state_n    = ST_ARB;
        end else if (io_req[owner]) begin
          io_gnt = owner_oh;
          io_D   = io_data[int'(owner)*WIDTH +: WIDTH];
          if (io_lock[owner]) begin
            if (hold_cnt != HW'(MAX_HOLD))
              hold_n = hold_cnt + 1'b1;
          end else begin
            state_n = ST_ARB;
          end
        end else if (!io_lock[owner]) begin
          state_n = ST_ARB;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  assign io_rd_data = io_Q;
  assign io_owner   = owner;
  assign io_locked  = (state == ST_LOCKED);

endmodule

// File: tb/tb_nreg_arbiter.sv
// tb/tb_nreg_arbiter.sv - directed self-checking bench for nreg_arbiter with an NReg model
module tb_nreg_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  io_req;
  logic [3:0]  io_lock;
  logic [31:0] io_data;
  logic [3:0]  io_gnt;
  logic [7:0]  io_D;
  logic [7:0]  io_Q;
  logic [7:0]  io_rd_data;
  logic [1:0]  io_owner;
  logic        io_locked;
  logic        io_preempt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // NReg: plain register, no enable and no reset.
  always @(posedge clk) io_Q <= io_D;

  nreg_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .io_req     (io_req),
    .io_lock    (io_lock),
    .io_data    (io_data),
    .io_gnt     (io_gnt),
    .io_D       (io_D),
    .io_Q       (io_Q),
    .io_rd_data (io_rd_data),
    .io_owner   (io_owner),
    .io_locked  (io_locked),
    .io_preempt (io_preempt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  int rr_exp[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    reset_n = 1'b0;
    io_req  = '0;
    io_lock = '0;
    io_data = '0;
    repeat (3) tick;
    chk("rst_gnt", io_gnt, 0);
    chk("rst_D", io_D, 0);
    chk("rst_locked", io_locked, 0);
    chk("rst_owner", io_owner, 0);
    chk("rst_preempt", io_preempt, 0);

    // INIT cycle clears the register
    reset_n = 1'b1;
    settle;
    chk("init_D", io_D, 8'h00);
    chk("init_gnt", io_gnt, 0);
    tick;
    for (int k = 0; k < 5; k++) begin
      settle;
      chk("idle_Q", io_rd_data, 8'h00);
      chk("idle_D", io_D, 8'h00);
      tick;
    end

    // single write from requester 0
    io_req  = 4'b0001;
    io_data = 32'h0000_00A5;
    settle;
    chk("w0_gnt", io_gnt, 4'b0001);
    chk("w0_D", io_D, 8'hA5);
    tick;
    io_req = '0;
    for (int k = 0; k < 10; k++) begin
      settle;
      chk("hold_Q", io_rd_data, 8'hA5);
      chk("hold_D", io_D, 8'hA5);
      chk("hold_gnt", io_gnt, 0);
      tick;
    end

    // all requesting; pointer is 1 after the write to requester 0
    io_req  = 4'b1111;
    io_data = 32'h1312_1110;
    for (int k = 0; k < 8; k++) begin
      settle;
      if (k > 0) chk("rr_Q", io_rd_data, 8'h10 + rr_exp[k-1]);
      chk("rr_gnt", io_gnt, 4'b0001 << rr_exp[k]);
      chk("rr_D", io_D, 8'h10 + rr_exp[k]);
      tick;
    end
    io_req = '0;
    settle;
    chk("rr_Q_last", io_rd_data, 8'h10);

    // locked burst from requester 2 with a no-grant hold in the middle
    io_req  = 4'b0100;
    io_lock = 4'b0100;
    io_data = 32'h0001_0000;
    settle;
    chk("lk1_gnt", io_gnt, 4'b0100);
    chk("lk1_locked", io_locked, 0);
    tick;
    io_data = 32'h0002_0000;
    settle;
    chk("lk2_locked", io_locked, 1);
    chk("lk2_owner", io_owner, 2);
    chk("lk2_gnt", io_gnt, 4'b0100);
    chk("lk2_Q", io_rd_data, 8'h01);
    tick;
    io_req = '0;
    settle;
    chk("lkh_gnt", io_gnt, 0);
    chk("lkh_locked", io_locked, 1);
    chk("lkh_D", io_D, 8'h02);
    tick;
    io_req  = 4'b0100;
    io_lock = '0;
    io_data = 32'h0003_0000;
    settle;
    chk("lk3_gnt", io_gnt, 4'b0100);
    chk("lk3_D", io_D, 8'h03);
    chk("lk3_locked", io_locked, 1);
    tick;
    io_req = '0;
    settle;
    chk("lk_rel_locked", io_locked, 0);
    chk("lk_rel_Q", io_rd_data, 8'h03);
    chk("lk_rel_gnt", io_gnt, 0);
    tick;

    // preemption: requester 0 waits behind a permanent lock on 2
    io_req  = 4'b0100;
    io_lock = 4'b0100;
    io_data = 32'h0020_0030;
    settle;
    chk("pe_first_gnt", io_gnt, 4'b0100);
    tick;
    io_req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      settle;
      chk("pe_hold_gnt", io_gnt, 4'b0100);
      chk("pe_hold_pre", io_preempt, 0);
      tick;
    end
    settle;
    chk("pe_pulse", io_preempt, 1);
    chk("pe_nogrant", io_gnt, 0);
    chk("pe_D_hold", io_D, 8'h20);
    tick;
    settle;
    chk("pe_after_pre", io_preempt, 0);
    chk("pe_after_locked", io_locked, 0);
    chk("pe_gnt0", io_gnt, 4'b0001);
    chk("pe_D0", io_D, 8'h30);
    tick;
    io_req = 4'b0100;
    settle;
    chk("pe_relock_gnt", io_gnt, 4'b0100);
    tick;
    settle;
    chk("pe_relock_locked", io_locked, 1);

    // asynchronous reset while locked
    reset_n = 1'b0;
    settle;
    chk("ar_gnt", io_gnt, 0);
    chk("ar_locked", io_locked, 0);
    chk("ar_D", io_D, 0);
    chk("ar_owner", io_owner, 0);
    tick;
    io_req  = '0;
    io_lock = '0;
    reset_n = 1'b1;
    settle;
    chk("ar_init_D", io_D, 8'h00);
    tick;
    settle;
    chk("ar_Q", io_rd_data, 8'h00);
    chk("ar_idle_gnt", io_gnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
